cim_macro_seq: RTL and testbench
================================

CIM_MACRO_SEQ -- requirements
Module: cim_macro_seq

Interface
REQ-001 The module SHALL have parameters: ROWS 16, row count; COLS 16, column count; ADC_W 4, bits per column ADC result.
REQ-002 The module SHALL have timing parameters: PRE_CYC 2, precharge cycles; WR_CYC 2, write cycles; SA_CYC 1, sense cycles; EVAL_CYC 2, evaluate cycles; ADC_CYC 4, conversion cycles (each ≥1).
REQ-003 The module SHALL use one clock; reset is asynchronous and active-high.
REQ-004 The module SHALL have these ports (name  direction  width  meaning):
- CLK  in  1  clock
- RST  in  1  async active-high reset
- CMD_VALID  in  1  command offered
- CMD_READY  out  1  command accepted when both high
- CMD_OP  in  2  00 write, 01 read, 10 compute, 11 reserved
- CMD_ROW  in  4  target row (write/read)
- CMD_DATA  in  16  write data (write) or input vector (compute)
- WWL  out  ROWS  write wordlines
- RWL  out  ROWS  read wordlines
- RWLB  out  ROWS  complementary read wordlines
- Din  out  COLS  write data
- WE  out  1  write enable
- PRE_SRAM  out  1  bitline precharge
- PRE_VLSA  out  1  voltage sense-amp precharge
- PRE_CLSA  out  1  current sense-amp precharge
- PRE_A  out  1  ADC precharge
- SAEN  out  1  sense-amp enable
- VCLP  out  1  bitline clamp enable
- EN  out  1  ADC enable
- SA_OUT  in  COLS  sense-amp result from macro
- ADC_OUT  in  COLS*ADC_W  column ADC results; column k at bits [4k+3:4k]
- RSP_VALID  out  1  response available
- RSP_READY  in  1  response consumed when both high
- RSP_DATA  out  COLS*ADC_W  response payload
- RSP_ERR  out  1  reserved opcode flag

Function
REQ-005 All outputs SHALL be registered; all macro control outputs are active-high and idle at 0.
REQ-006 The FSM SHALL have states IDLE, PRE, WRITE, SENSE, EVAL, CONV, RESP; CMD_READY SHALL be 1 only in IDLE.
REQ-007 One command SHALL be outstanding at a time; a command is accepted on the edge where CMD_VALID and CMD_READY are both 1, and CMD_OP/ROW/DATA SHALL be latched then.
REQ-008 Write SHALL go IDLE→WRITE for WR_CYC cycles (WE=1, WWL one-hot at row, Din=data), then RESP with RSP_DATA=0.
REQ-009 Read SHALL go IDLE→PRE for PRE_CYC cycles (PRE_SRAM=PRE_VLSA=1), then SENSE for SA_CYC cycles (RWL one-hot at row, SAEN=1).
REQ-010 On the last SENSE cycle, SA_OUT SHALL be captured; RSP_DATA SHALL be zero-extended SA_OUT.
REQ-011 Compute SHALL go IDLE→PRE for PRE_CYC cycles (PRE_SRAM=PRE_CLSA=PRE_A=1).
REQ-012 Compute SHALL then go to EVAL for EVAL_CYC cycles (RWL=vector, RWLB=~vector, VCLP=1, EN=1).
REQ-013 Compute SHALL then go to CONV for ADC_CYC cycles (EN=1, wordlines 0), capture ADC_OUT on the last CONV cycle, then go to RESP.
REQ-014 A reserved opcode SHALL go directly to RESP with RSP_ERR=1 and RSP_DATA=0, with no macro activity.
REQ-015 In RESP, RSP_VALID=1 and RSP_DATA/RSP_ERR SHALL be held stable until RSP_READY=1; the FSM SHALL then return to IDLE.
REQ-016 With default parameters and the command accepted at edge 0, RSP_VALID SHALL rise after edge 3 (write), 4 (read) or 9 (compute), and after edge 1 (reserved).
REQ-017 WE, SAEN and EN SHALL never be 1 while any precharge output is 1.
REQ-018 WWL and RWL SHALL never both be nonzero.

Reset
REQ-019 RST SHALL immediately force state IDLE, all outputs 0 (CMD_READY 0 while RST high) and captured data 0, including mid-operation.
REQ-020 CMD_READY SHALL be 1 on the first edge after RST is released.

Structure
REQ-021 The shared package cim_seq_pkg SHALL hold the opcode encodings, the state enum and the default timing constants.
REQ-022 A sub-module cim_phase_timer SHALL provide a loadable down-counter that asserts done on the final cycle of each phase.

Verification
REQ-023 Write op, row 5, data 0xA5A5 → WE=1, WWL=0x0020, Din=0xA5A5 for 2 cycles; then RSP_VALID, RSP_DATA=0.
REQ-024 Read op, row 3, SA_OUT=0x1234 → PRE 2 cycles, then SAEN with RWL=0x0008; then RSP_DATA=0x1234.
REQ-025 Compute op, vector 0x00FF, ADC_OUT=0x0123…CDEF → RWL=0x00FF, RWLB=0xFF00 for 2 cycles, EN for 6 cycles; RSP_DATA equals the ADC_OUT value sampled on the last CONV cycle.
REQ-026 RSP_READY held 0 for 5 cycles → RSP_VALID and RSP_DATA stable throughout; CMD_READY stays 0 until the handshake completes.
REQ-027 RST asserted during EVAL → all outputs 0 immediately; CMD_READY=1 on the first edge after release; no stale response is issued.
REQ-028 Opcode 11 → RSP_ERR=1 after one cycle; all macro controls remain 0.

Source files
------------

// File: rtl/cim_seq_pkg.sv
// Shared definitions for the CIM macro sequencer.
// Holds the command opcode encodings, the sequencer state enum, the
// default phase lengths (in clock cycles), the phase-timer width and the
// bundle of single-bit macro control strobes.
package cim_seq_pkg;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'b00,
        OP_READ    = 2'b01,
        OP_COMPUTE = 2'b10,
        OP_RSVD    = 2'b11
    } cim_op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        WRITE = 3'd2,
        SENSE = 3'd3,
        EVAL  = 3'd4,
        CONV  = 3'd5,
        RESP  = 3'd6
    } cim_state_e;

    localparam int PRE_CYC_DEF  = 2;
    localparam int WR_CYC_DEF   = 2;
    localparam int SA_CYC_DEF   = 1;
    localparam int EVAL_CYC_DEF = 2;
    localparam int ADC_CYC_DEF  = 4;

    // Wide enough for any phase length up to 255 cycles.
    localparam int CNT_W = 8;

    // Single-bit macro strobes, all active-high, idle at 0.
    typedef struct packed {
        logic we;
        logic pre_sram;
        logic pre_vlsa;
        logic pre_clsa;
        logic pre_a;
        logic saen;
        logic vclp;
        logic en;
    } macro_ctl_t;

endpackage

// File: rtl/cim_phase_timer.sv
// Loadable down-counter that measures the length of one sequencer phase.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   load      - start a new phase on this edge
//   load_val  - length of the new phase in cycles (must be >= 1)
//   done      - high during the final cycle of the current phase
module cim_phase_timer
    import cim_seq_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // The count holds the number of cycles remaining after the current one,
    // so a one-cycle phase is done immediately.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val - W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/cim_macro_seq.sv
// Command sequencer for a compute-in-memory SRAM macro.
// Accepts one write/read/compute command at a time, drives the macro's
// precharge, wordline, sense and ADC controls through timed phases, and
// returns one response per command.
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both 1; the sender holds its payload stable until that edge.
// Ports:
//   CLK, RST              - clock, asynchronous active-high reset
//   CMD_VALID/READY/OP/ROW/DATA - command channel (ready only in IDLE)
//   WWL, RWL, RWLB, Din   - macro wordlines and write data
//   WE, PRE_SRAM, PRE_VLSA, PRE_CLSA, PRE_A, SAEN, VCLP, EN - macro strobes
//   SA_OUT, ADC_OUT       - macro read / compute results
//   RSP_VALID/READY/DATA/ERR - response channel
//   dbg_state             - current sequencer state
// Every output is a flop. The accept edge only latches the command; the
// first phase begins on the following edge, so each output flop tracks the
// state register exactly.
module cim_macro_seq
    import cim_seq_pkg::*;
#(
    parameter int ROWS     = 16,
    parameter int COLS     = 16,
    parameter int ADC_W    = 4,
    parameter int PRE_CYC  = PRE_CYC_DEF,
    parameter int WR_CYC   = WR_CYC_DEF,
    parameter int SA_CYC   = SA_CYC_DEF,
    parameter int EVAL_CYC = EVAL_CYC_DEF,
    parameter int ADC_CYC  = ADC_CYC_DEF
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CMD_VALID,
    output logic                     CMD_READY,
    input  logic [1:0]               CMD_OP,
    input  logic [$clog2(ROWS)-1:0]  CMD_ROW,
    input  logic [COLS-1:0]          CMD_DATA,
    output logic [ROWS-1:0]          WWL,
    output logic [ROWS-1:0]          RWL,
    output logic [ROWS-1:0]          RWLB,
    output logic [COLS-1:0]          Din,
    output logic                     WE,
    output logic                     PRE_SRAM,
    output logic                     PRE_VLSA,
    output logic                     PRE_CLSA,
    output logic                     PRE_A,
    output logic                     SAEN,
    output logic                     VCLP,
    output logic                     EN,
    input  logic [COLS-1:0]          SA_OUT,
    input  logic [COLS*ADC_W-1:0]    ADC_OUT,
    output logic                     RSP_VALID,
    input  logic                     RSP_READY,
    output logic [COLS*ADC_W-1:0]    RSP_DATA,
    output logic                     RSP_ERR,
    output logic [2:0]               dbg_state
);

    cim_state_e                state_q, state_d;
    logic                      pend_q, pend_d;
    cim_op_e                   op_q, op_d;
    logic [$clog2(ROWS)-1:0]   row_q, row_d;
    logic [COLS-1:0]           data_q, data_d;
    logic [COLS*ADC_W-1:0]     rsp_data_q, rsp_data_d;
    logic                      rsp_err_q, rsp_err_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic                      cmd_ready_q, cmd_ready_d;
    macro_ctl_t                ctl_q, ctl_d;
    logic [ROWS-1:0]           wwl_q, wwl_d;
    logic [ROWS-1:0]           rwl_q, rwl_d;
    logic [ROWS-1:0]           rwlb_q, rwlb_d;
    logic [COLS-1:0]           din_q, din_d;

    logic                      tmr_load;
    logic [CNT_W-1:0]          tmr_val;
    logic                      tmr_done;

    cim_phase_timer #(.W(CNT_W)) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Next state, command latch and response capture.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        op_d       = op_q;
        row_d      = row_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    pend_d = 1'b0;
                    case (op_q)
                        OP_WRITE:             state_d = WRITE;
                        OP_READ, OP_COMPUTE:  state_d = PRE;
                        default: begin
                            state_d   = RESP;
                            rsp_err_d = 1'b1;
                        end
                    endcase
                end else if (CMD_VALID && CMD_READY) begin
                    pend_d = 1'b1;
                    op_d   = cim_op_e'(CMD_OP);
                    row_d  = CMD_ROW;
                    data_d = CMD_DATA;
                end
            end
            PRE:   if (tmr_done) state_d = (op_q == OP_READ) ? SENSE : EVAL;
            WRITE: if (tmr_done) state_d = RESP;
            SENSE: begin
                if (tmr_done) begin
                    state_d                = RESP;
                    rsp_data_d             = '0;
                    rsp_data_d[COLS-1:0]   = SA_OUT;
                end
            end
            EVAL:  if (tmr_done) state_d = CONV;
            CONV: begin
                if (tmr_done) begin
                    state_d    = RESP;
                    rsp_data_d = ADC_OUT;
                end
            end
            RESP: begin
                // Clearing here means write and reserved responses carry 0.
                if (RSP_READY) begin
                    state_d    = IDLE;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state so outputs line up with state_q.
    always_comb begin
        ctl_d       = '0;
        wwl_d       = '0;
        rwl_d       = '0;
        rwlb_d      = '0;
        din_d       = '0;
        tmr_load    = 1'b0;
        tmr_val     = CNT_W'(1);
        cmd_ready_d = (state_d == IDLE) && !pend_d;
        rsp_valid_d = (state_d == RESP);
        case (state_d)
            PRE: begin
                ctl_d.pre_sram = 1'b1;
                ctl_d.pre_vlsa = (op_d == OP_READ);
                ctl_d.pre_clsa = (op_d == OP_COMPUTE);
                ctl_d.pre_a    = (op_d == OP_COMPUTE);
                tmr_val        = CNT_W'(PRE_CYC);
            end
            WRITE: begin
                ctl_d.we      = 1'b1;
                wwl_d[row_d]  = 1'b1;
                din_d         = data_d;
                tmr_val       = CNT_W'(WR_CYC);
            end
            SENSE: begin
                ctl_d.saen    = 1'b1;
                rwl_d[row_d]  = 1'b1;
                tmr_val       = CNT_W'(SA_CYC);
            end
            EVAL: begin
                ctl_d.vclp = 1'b1;
                ctl_d.en   = 1'b1;
                rwl_d      = ROWS'(data_d);
                rwlb_d     = ~ROWS'(data_d);
                tmr_val    = CNT_W'(EVAL_CYC);
            end
            CONV: begin
                ctl_d.en = 1'b1;
                tmr_val  = CNT_W'(ADC_CYC);
            end
            default: ;
        endcase
        // Restart the timer on entry to any timed phase.
        if (state_d != state_q && state_d != IDLE && state_d != RESP) begin
            tmr_load = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            op_q        <= OP_WRITE;
            row_q       <= '0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            ctl_q       <= '0;
            wwl_q       <= '0;
            rwl_q       <= '0;
            rwlb_q      <= '0;
            din_q       <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            op_q        <= op_d;
            row_q       <= row_d;
            data_q      <= data_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            ctl_q       <= ctl_d;
            wwl_q       <= wwl_d;
            rwl_q       <= rwl_d;
            rwlb_q      <= rwlb_d;
            din_q       <= din_d;
        end
    end

    assign CMD_READY = cmd_ready_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_DATA  = rsp_data_q;
    assign RSP_ERR   = rsp_err_q;
    assign WWL       = wwl_q;
    assign RWL       = rwl_q;
    assign RWLB      = rwlb_q;
    assign Din       = din_q;
    assign WE        = ctl_q.we;
    assign PRE_SRAM  = ctl_q.pre_sram;
    assign PRE_VLSA  = ctl_q.pre_vlsa;
    assign PRE_CLSA  = ctl_q.pre_clsa;
    assign PRE_A     = ctl_q.pre_a;
    assign SAEN      = ctl_q.saen;
    assign VCLP      = ctl_q.vclp;
    assign EN        = ctl_q.en;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cim_macro_seq.sv
// Directed bench for cim_macro_seq: a table of commands with hand-computed
// per-cycle control patterns and responses, plus reset sequences.
module tb_cim_macro_seq;
    import cim_seq_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [1:0]  CMD_OP;
    logic [3:0]  CMD_ROW;
    logic [15:0] CMD_DATA;
    logic [15:0] WWL, RWL, RWLB, Din;
    logic        WE, PRE_SRAM, PRE_VLSA, PRE_CLSA, PRE_A, SAEN, VCLP, EN;
    logic [15:0] SA_OUT;
    logic [63:0] ADC_OUT;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [63:0] RSP_DATA;
    logic        RSP_ERR;
    logic [2:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  row;
        logic [15:0] data;
        logic [15:0] sa;
        logic [63:0] adc;
        int          lat;
        logic [63:0] exp_data;
        logic        exp_err;
        int          hold;
    } vec_t;

    typedef struct packed {
        logic        cmd_ready;
        logic        rsp_valid;
        logic        we, pre_sram, pre_vlsa, pre_clsa, pre_a, saen, vclp, en;
        logic [15:0] wwl, rwl, rwlb, din;
    } ctrl_t;

    vec_t vecs[8];

    cim_macro_seq dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
        .CMD_ROW(CMD_ROW), .CMD_DATA(CMD_DATA),
        .WWL(WWL), .RWL(RWL), .RWLB(RWLB), .Din(Din), .WE(WE),
        .PRE_SRAM(PRE_SRAM), .PRE_VLSA(PRE_VLSA), .PRE_CLSA(PRE_CLSA),
        .PRE_A(PRE_A), .SAEN(SAEN), .VCLP(VCLP), .EN(EN),
        .SA_OUT(SA_OUT), .ADC_OUT(ADC_OUT),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic ctrl_t act_ctrl();
        ctrl_t c;
        c.cmd_ready = CMD_READY; c.rsp_valid = RSP_VALID;
        c.we = WE; c.pre_sram = PRE_SRAM; c.pre_vlsa = PRE_VLSA;
        c.pre_clsa = PRE_CLSA; c.pre_a = PRE_A; c.saen = SAEN;
        c.vclp = VCLP; c.en = EN;
        c.wwl = WWL; c.rwl = RWL; c.rwlb = RWLB; c.din = Din;
        return c;
    endfunction

    // Expected pattern k cycles after the accept edge (default timing:
    // PRE 2, WRITE 2, SENSE 1, EVAL 2, CONV 4, then RESP at k == lat).
    function automatic ctrl_t exp_ctrl(input vec_t v, input int k);
        ctrl_t c;
        logic [15:0] oh;
        c  = '0;
        oh = 16'h0001 << v.row;
        if (k == v.lat) begin
            c.rsp_valid = 1'b1;
        end else begin
            case (v.op)
                2'b00: begin c.we = 1'b1; c.wwl = oh; c.din = v.data; end
                2'b01: begin
                    if (k <= 2) begin c.pre_sram = 1'b1; c.pre_vlsa = 1'b1; end
                    else begin c.rwl = oh; c.saen = 1'b1; end
                end
                2'b10: begin
                    if (k <= 2) begin
                        c.pre_sram = 1'b1; c.pre_clsa = 1'b1; c.pre_a = 1'b1;
                    end else if (k <= 4) begin
                        c.rwl = v.data; c.rwlb = ~v.data; c.vclp = 1'b1; c.en = 1'b1;
                    end else begin
                        c.en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        return c;
    endfunction

    task automatic inv_chk();
        chk("pre_exclusive", 128'((WE | SAEN | EN) & (PRE_SRAM | PRE_VLSA | PRE_CLSA | PRE_A)), 128'(0));
        chk("wl_exclusive", 128'((|WWL) && (|RWL)), 128'(0));
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!CMD_READY && n < 20) begin
            step();
            n++;
        end
        chk("cmd_ready_wait", 128'(CMD_READY), 128'(1));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        wait_ready();
        CMD_VALID = 1'b1; CMD_OP = v.op; CMD_ROW = v.row; CMD_DATA = v.data;
        step();
        // Scramble the command bus to confirm the DUT latched it.
        CMD_VALID = 1'b0; CMD_ROW = ~v.row; CMD_DATA = ~v.data;
        chk($sformatf("v%0d_accept_ready_low", idx), 128'(CMD_READY), 128'(0));
        for (int k = 1; k <= v.lat; k++) begin
            // Only the value present on the final phase cycle is the right one.
            SA_OUT  = (k == v.lat) ? v.sa  : ~v.sa;
            ADC_OUT = (k == v.lat) ? v.adc : ~v.adc;
            step();
            chk($sformatf("v%0d_ctrl_k%0d", idx, k), 128'(act_ctrl()), 128'(exp_ctrl(v, k)));
            inv_chk();
        end
        SA_OUT  = ~v.sa;
        ADC_OUT = ~v.adc;
        chk($sformatf("v%0d_rsp_data", idx), 128'(RSP_DATA), 128'(v.exp_data));
        chk($sformatf("v%0d_rsp_err", idx), 128'(RSP_ERR), 128'(v.exp_err));
        for (int h = 0; h < v.hold; h++) begin
            step();
            chk($sformatf("v%0d_hold_ctrl%0d", idx, h), 128'(act_ctrl()), 128'(exp_ctrl(v, v.lat)));
            chk($sformatf("v%0d_hold_data%0d", idx, h), 128'({RSP_DATA, RSP_ERR}), 128'({v.exp_data, v.exp_err}));
        end
        RSP_READY = 1'b1;
        step();
        RSP_READY = 1'b0;
        chk($sformatf("v%0d_rsp_done", idx), 128'(RSP_VALID), 128'(0));
        chk($sformatf("v%0d_ready_back", idx), 128'(CMD_READY), 128'(1));
    endtask

    initial begin
        vecs[0] = '{2'b00, 4'd5,  16'hA5A5, 16'h0000, 64'h0, 3, 64'h0, 1'b0, 5};
        vecs[1] = '{2'b01, 4'd3,  16'h0000, 16'h1234, 64'h0, 4, 64'h1234, 1'b0, 0};
        vecs[2] = '{2'b10, 4'd0,  16'h00FF, 16'h0000, 64'h0123456789ABCDEF, 9, 64'h0123456789ABCDEF, 1'b0, 2};
        vecs[3] = '{2'b11, 4'd0,  16'hFFFF, 16'hFFFF, 64'hFFFF, 1, 64'h0, 1'b1, 1};
        vecs[4] = '{2'b01, 4'd15, 16'h0000, 16'hFFFF, 64'h0, 4, 64'hFFFF, 1'b0, 0};
        vecs[5] = '{2'b00, 4'd0,  16'h0001, 16'h0000, 64'h0, 3, 64'h0, 1'b0, 1};
        vecs[6] = '{2'b10, 4'd0,  16'hFFFF, 16'h0000, 64'hFEDCBA9876543210, 9, 64'hFEDCBA9876543210, 1'b0, 0};
        vecs[7] = '{2'b10, 4'd0,  16'h8001, 16'h0000, 64'h0000000000000001, 9, 64'h0000000000000001, 1'b0, 0};

        RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = 2'b00; CMD_ROW = 4'd0;
        CMD_DATA = 16'h0; SA_OUT = 16'h0; ADC_OUT = 64'h0; RSP_READY = 1'b0;

        // Reset state, including CMD_READY low while reset is held.
        step();
        step();
        chk("rst_ctrl", 128'(act_ctrl()), 128'(0));
        chk("rst_rsp", 128'({RSP_DATA, RSP_ERR}), 128'(0));
        chk("rst_dbg_idle", 128'(dbg_state), 128'(IDLE));
        RST = 1'b0;
        step();
        chk("ready_after_release", 128'(CMD_READY), 128'(1));

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset in the middle of EVAL: compute accepted, EVAL after edge 3.
        wait_ready();
        CMD_VALID = 1'b1; CMD_OP = 2'b10; CMD_ROW = 4'd2; CMD_DATA = 16'h0F0F;
        ADC_OUT = 64'hDEADBEEFDEADBEEF;
        step();
        CMD_VALID = 1'b0;
        step(); step(); step();
        chk("mid_eval_en", 128'({EN, VCLP, RWL}), 128'({1'b1, 1'b1, 16'h0F0F}));
        #2;
        RST = 1'b1;
        #1;
        chk("mid_rst_ctrl", 128'(act_ctrl()), 128'(0));
        chk("mid_rst_rsp", 128'({RSP_DATA, RSP_ERR}), 128'(0));
        step();
        chk("mid_rst_held", 128'(act_ctrl()), 128'(0));
        RST = 1'b0;
        step();
        chk("mid_rst_ready", 128'(CMD_READY), 128'(1));
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("no_stale_rsp%0d", c), 128'({RSP_VALID, EN, RWL}), 128'(0));
            step();
        end

        // Normal operation resumes after the interrupted command.
        run_vec(vecs[1], 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
